// File: rtl/panda_ram_arbiter_if.sv
// Requester and RAM-side signal bundle for panda_ram_arbiter.
// The slave modport belongs to the arbiter; master belongs to the core/RAM side.
interface panda_ram_arbiter_if #(
  parameter int DataWidth = 32,
  parameter int Depth     = 1024,
  parameter int AddrWidth = 32
);
  logic                       instr_req_i;
  logic [AddrWidth-1:0]       instr_addr_i;
  logic                       instr_gnt_o;
  logic                       instr_rvalid_o;
  logic [DataWidth-1:0]       instr_rdata_o;
  logic                       instr_err_o;

  logic                       data_req_i;
  logic [DataWidth/8-1:0]     data_we_i;
  logic [AddrWidth-1:0]       data_addr_i;
  logic [DataWidth-1:0]       data_wdata_i;
  logic                       data_gnt_o;
  logic                       data_rvalid_o;
  logic                       data_err_o;
  logic [DataWidth-1:0]       data_rdata_o;

  logic                       ram_ce_o;
  logic [DataWidth/8-1:0]     ram_we_o;
  logic [$clog2(Depth)-1:0]   ram_addr_o;
  logic [DataWidth-1:0]       ram_wdata_o;
  logic [DataWidth-1:0]       ram_rdata_i;

  modport slave (
    input  instr_req_i, instr_addr_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    input  data_req_i, data_we_i, data_addr_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o,
    output ram_ce_o, ram_we_o, ram_addr_o, ram_wdata_o,
    input  ram_rdata_i
  );

  modport master (
    output instr_req_i, instr_addr_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    output data_req_i, data_we_i, data_addr_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o,
    input  ram_ce_o, ram_we_o, ram_addr_o, ram_wdata_o,
    output ram_rdata_i
  );
endinterface

// File: rtl/panda_ram_arbiter.sv
// Shares one single-port byte-writable RAM between fetch and load/store ports.
// PANDA_RAM_ARB_RR_EN selects round-robin arbitration; default is data-over-fetch priority.
module panda_ram_arbiter #(
  parameter int DataWidth = 32,
  parameter int Depth     = 1024,
  parameter int AddrWidth = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  panda_ram_arbiter_if.slave bus
);
  localparam int WA = $clog2(Depth);

  typedef struct packed {
    logic valid;
    logic owner;   // 1 = data port
    logic err;
  } rsp_t;

  logic d_inr, i_inr, pick_data, d_gnt, i_gnt;
  rsp_t rsp_q;

  // In range when every bit above the word index is zero.
  assign d_inr = (bus.data_addr_i  >> (WA + 2)) == '0;
  assign i_inr = (bus.instr_addr_i >> (WA + 2)) == '0;

`ifdef PANDA_RAM_ARB_RR_EN
  logic last_data_q;
  assign pick_data = bus.data_req_i & (~bus.instr_req_i | ~last_data_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)             last_data_q <= 1'b0;
    else if (d_gnt | i_gnt)  last_data_q <= d_gnt;
  end
`else
  assign pick_data = bus.data_req_i;
`endif

  assign d_gnt = rst_ni & pick_data;
  assign i_gnt = rst_ni & bus.instr_req_i & ~pick_data;

  assign bus.data_gnt_o  = d_gnt;
  assign bus.instr_gnt_o = i_gnt;

  assign bus.ram_ce_o    = (d_gnt & d_inr) | (i_gnt & i_inr);
  assign bus.ram_we_o    = (d_gnt & d_inr) ? bus.data_we_i : '0;
  assign bus.ram_addr_o  = i_gnt ? bus.instr_addr_i[WA+1:2] : bus.data_addr_i[WA+1:2];
  assign bus.ram_wdata_o = bus.data_wdata_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_q <= '0;
    end else begin
      rsp_q.valid <= d_gnt | i_gnt;
      rsp_q.owner <= d_gnt;
      rsp_q.err   <= d_gnt ? ~d_inr : ~i_inr;
    end
  end

  assign bus.data_rvalid_o  = rsp_q.valid &  rsp_q.owner;
  assign bus.instr_rvalid_o = rsp_q.valid & ~rsp_q.owner;
  assign bus.data_err_o     = bus.data_rvalid_o  & rsp_q.err;
  assign bus.instr_err_o    = bus.instr_rvalid_o & rsp_q.err;
  assign bus.data_rdata_o   = (bus.data_rvalid_o  & ~rsp_q.err) ? bus.ram_rdata_i : '0;
  assign bus.instr_rdata_o  = (bus.instr_rvalid_o & ~rsp_q.err) ? bus.ram_rdata_i : '0;
endmodule

// File: tb/tb_panda_ram_arbiter.sv
// Self-checking bench for panda_ram_arbiter with a behavioural RAM behind it.
module tb_panda_ram_arbiter;
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  panda_ram_arbiter_if #(.DataWidth(32), .Depth(1024), .AddrWidth(32)) bus ();
  panda_ram_arbiter #(.DataWidth(32), .Depth(1024), .AddrWidth(32)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .bus(bus));

  // Read-first byte-writable RAM, one cycle read latency.
  logic [31:0] mem [0:1023];
  logic [31:0] ram_q = '0;
  initial for (int i = 0; i < 1024; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (bus.ram_ce_o) begin
      for (int b = 0; b < 4; b++)
        if (bus.ram_we_o[b]) mem[bus.ram_addr_o][8*b +: 8] <= bus.ram_wdata_o[8*b +: 8];
      ram_q <= mem[bus.ram_addr_o];
    end
  end
  assign bus.ram_rdata_i = ram_q;

  typedef struct {
    logic dreq; logic [3:0] dwe; logic [31:0] daddr; logic [31:0] dwdata;
    logic ireq; logic [31:0] iaddr;
    logic edg; logic eig; logic ece; logic [9:0] eaddr; logic [3:0] ewe;
    logic [31:0] erdata; logic eerr;
  } vec_t;

  typedef struct {
    logic iv; logic ie; logic [31:0] ird;
    logic dv; logic de; logic [31:0] drd;
  } rsp_t;

  rsp_t q[$];
  vec_t vt[13];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic dreq, input logic [3:0] dwe, input logic [31:0] daddr,
                              input logic [31:0] dwdata, input logic ireq, input logic [31:0] iaddr,
                              input logic edg, input logic eig, input logic ece, input logic [9:0] eaddr,
                              input logic [3:0] ewe, input logic [31:0] erdata, input logic eerr);
    vec_t v;
    v.dreq = dreq; v.dwe = dwe; v.daddr = daddr; v.dwdata = dwdata;
    v.ireq = ireq; v.iaddr = iaddr;
    v.edg = edg; v.eig = eig; v.ece = ece; v.eaddr = eaddr; v.ewe = ewe;
    v.erdata = erdata; v.eerr = eerr;
    return v;
  endfunction

  task automatic check_rsp(input string tag);
    rsp_t e;
    if (q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s scoreboard: queue empty, response expected", tag);
      return;
    end
    e = q.pop_front();
    chk({tag, " instr_rvalid"}, {31'b0, bus.instr_rvalid_o}, {31'b0, e.iv});
    chk({tag, " instr_err"},    {31'b0, bus.instr_err_o},    {31'b0, e.ie});
    chk({tag, " instr_rdata"},  bus.instr_rdata_o,           e.ird);
    chk({tag, " data_rvalid"},  {31'b0, bus.data_rvalid_o},  {31'b0, e.dv});
    chk({tag, " data_err"},     {31'b0, bus.data_err_o},     {31'b0, e.de});
    chk({tag, " data_rdata"},   bus.data_rdata_o,            e.drd);
  endtask

  task automatic step(input vec_t v, input string tag);
    rsp_t e;
    @(negedge clk);
    rst_ni = 1'b1;
    bus.data_req_i = v.dreq; bus.data_we_i = v.dwe; bus.data_addr_i = v.daddr;
    bus.data_wdata_i = v.dwdata; bus.instr_req_i = v.ireq; bus.instr_addr_i = v.iaddr;
    #1;
    chk({tag, " data_gnt"},  {31'b0, bus.data_gnt_o},  {31'b0, v.edg});
    chk({tag, " instr_gnt"}, {31'b0, bus.instr_gnt_o}, {31'b0, v.eig});
    chk({tag, " ram_ce"},    {31'b0, bus.ram_ce_o},    {31'b0, v.ece});
    chk({tag, " ram_we"},    {28'b0, bus.ram_we_o},    {28'b0, v.ewe});
    if (v.ece) chk({tag, " ram_addr"}, {22'b0, bus.ram_addr_o}, {22'b0, v.eaddr});
    e.iv = v.eig; e.ie = v.eig & v.eerr; e.ird = v.eig ? v.erdata : '0;
    e.dv = v.edg; e.de = v.edg & v.eerr; e.drd = v.edg ? v.erdata : '0;
    q.push_back(e);
    @(posedge clk); #1;
    check_rsp(tag);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " instr_rvalid"}, {31'b0, bus.instr_rvalid_o}, 32'd0);
    chk({tag, " data_rvalid"},  {31'b0, bus.data_rvalid_o},  32'd0);
    chk({tag, " instr_rdata"},  bus.instr_rdata_o,           32'd0);
    chk({tag, " data_rdata"},   bus.data_rdata_o,            32'd0);
  endtask

  logic rr;

  initial begin
`ifdef PANDA_RAM_ARB_RR_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    //          dreq we     daddr         dwdata        ireq iaddr        dg   ig   ce   addr  we     rdata         err
    vt[0]  = mk(1, 4'h0, 32'h0000_0000, 32'h0,         1, 32'h0000_0004, 1,  0,   1,   10'd0, 4'h0, 32'h0,         0);
    vt[1]  = mk(1, 4'hF, 32'h0000_0010, 32'hDEADBEEF,  0, 32'h0,         1,  0,   1,   10'd4, 4'hF, 32'h0,         0);
    vt[2]  = mk(1, 4'h0, 32'h0000_0010, 32'h0,         0, 32'h0,         1,  0,   1,   10'd4, 4'h0, 32'hDEADBEEF,  0);
    vt[3]  = mk(1, 4'h2, 32'h0000_0011, 32'h0000AB00,  0, 32'h0,         1,  0,   1,   10'd4, 4'h2, 32'hDEADBEEF,  0);
    vt[4]  = mk(1, 4'h0, 32'h0000_0010, 32'h0,         0, 32'h0,         1,  0,   1,   10'd4, 4'h0, 32'hDEADABEF,  0);
    vt[5]  = mk(0, 4'h0, 32'h0,         32'h0,         1, 32'h0000_0013, 0,  1,   1,   10'd4, 4'h0, 32'hDEADABEF,  0);
    vt[6]  = mk(1, 4'hF, 32'hFFFF_0000, 32'h12345678,  0, 32'h0,         1,  0,   0,   10'd0, 4'h0, 32'h0,         1);
    vt[7]  = mk(0, 4'h0, 32'h0,         32'h0,         1, 32'h0000_1000, 0,  1,   0,   10'd0, 4'h0, 32'h0,         1);
    vt[8]  = mk(0, 4'h0, 32'h0,         32'h0,         0, 32'h0,         0,  0,   0,   10'd0, 4'h0, 32'h0,         0);
    // Contention: fetch last granted, so round-robin alternates starting with data.
    for (int i = 0; i < 4; i++) begin
      if (rr && (i % 2 == 1))
        vt[9+i] = mk(1, 4'h0, 32'h10, 32'h0, 1, 32'h0, 0, 1, 1, 10'd0, 4'h0, 32'h0, 0);
      else
        vt[9+i] = mk(1, 4'h0, 32'h10, 32'h0, 1, 32'h0, 1, 0, 1, 10'd4, 4'h0, 32'hDEADABEF, 0);
    end

    bus.data_req_i = 1'b1; bus.data_we_i = '0; bus.data_addr_i = '0; bus.data_wdata_i = '0;
    bus.instr_req_i = 1'b1; bus.instr_addr_i = 32'h4;
    repeat (2) @(posedge clk);
    #1;
    chk("reset data_gnt",  {31'b0, bus.data_gnt_o},  32'd0);
    chk("reset instr_gnt", {31'b0, bus.instr_gnt_o}, 32'd0);
    chk("reset ram_ce",    {31'b0, bus.ram_ce_o},    32'd0);
    chk("reset instr_err", {31'b0, bus.instr_err_o}, 32'd0);
    chk("reset data_err",  {31'b0, bus.data_err_o},  32'd0);
    chk_quiet("reset");

    for (int i = 0; i < 13; i++) step(vt[i], $sformatf("vec%0d", i));

    // Reset lands after a fetch grant but before its response edge.
    @(negedge clk);
    bus.data_req_i = 1'b0; bus.instr_req_i = 1'b1; bus.instr_addr_i = 32'h10;
    #1;
    chk("midrst instr_gnt pre", {31'b0, bus.instr_gnt_o}, 32'd1);
    chk("midrst ram_ce pre",    {31'b0, bus.ram_ce_o},    32'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("midrst instr_gnt in", {31'b0, bus.instr_gnt_o}, 32'd0);
    chk("midrst ram_ce in",    {31'b0, bus.ram_ce_o},    32'd0);
    @(posedge clk); #1;
    chk_quiet("midrst during");
    @(negedge clk);
    bus.instr_req_i = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    chk_quiet("midrst release");
    repeat (2) begin
      @(posedge clk); #1;
      chk_quiet("midrst after");
    end

    step(mk(1, 4'h0, 32'h10, 32'h0, 0, 32'h0, 1, 0, 1, 10'd4, 4'h0, 32'hDEADABEF, 0), "recover");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
